// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the RCPU memory path: arbiter states, owner codes and
// the CPU's memory-source selects.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      WRB  = 2'd2,
      P1   = 2'd3
   } arbState_t;

   localparam logic [1:0] OWN_IDLE = 2'd0;
   localparam logic [1:0] OWN_RD0  = 2'd1;
   localparam logic [1:0] OWN_WRB  = 2'd2;
   localparam logic [1:0] OWN_P1   = 2'd3;

   localparam logic [1:0] MEM_SRC_ALU  = 2'd0;
   localparam logic [1:0] MEM_SRC_LOAD = 2'd1;
   localparam logic [1:0] MEM_SRC_PC   = 2'd2;
   localparam logic [1:0] MEM_SRC_IMM  = 2'd3;

   function automatic logic [1:0] ownerOf(arbState_t s);
      logic [1:0] o;
      unique case (s)
         IDLE:    o = OWN_IDLE;
         RD0:     o = OWN_RD0;
         WRB:     o = OWN_WRB;
         default: o = OWN_P1;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_wb.sv
// write_buffer: synchronous FIFO posting RCPU writes, depth a power of two.
// Push and pop on a full FIFO in the same cycle are both honoured.
module write_buffer #(
   parameter int W     = 48,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wrPtr;
   logic [AW:0]  rdPtr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wrPtr[AW-1:0]] <= din;
   end

   // extra pointer bit separates full from empty
   assign empty = (wrPtr == rdPtr);
   assign full  = (wrPtr[AW] != rdPtr[AW]) &&
                  (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign head  = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory port arbiter between the RCPU (posted writes, stalled reads) and port 1.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int M        = 16,
   parameter int N        = 32,
   parameter int WB_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] addr0,
   input  logic [M-1:0] wdata0,
   input  logic         re0,
   input  logic         we0,
   output logic         ready0,
   output logic [M-1:0] rdata0,
   input  logic [N-1:0] addr1,
   input  logic [M-1:0] wdata1,
   input  logic         re1,
   input  logic         we1,
   output logic         ready1,
   output logic [M-1:0] rdata1,
   output logic [N-1:0] memAddr,
   output logic [M-1:0] memWrite,
   output logic         memRE,
   output logic         memWE,
   input  logic         memReady,
   input  logic [M-1:0] memRead,
   output logic [1:0]   owner,
   output logic         wbOverflow
);

   arbState_t state, nextState;

   logic           wbPush, wbPop, wbFull, wbEmpty;
   logic [N+M-1:0] wbHead;
   logic           c0Req, c1Req, pick1;
   arbState_t      c0Grant;

   write_buffer #(
      .W     (N + M),
      .DEPTH (WB_DEPTH)
   ) uWb (
      .clk   (clk),
      .rst   (rst),
      .push  (wbPush),
      .pop   (wbPop),
      .din   ({addr0, wdata0}),
      .full  (wbFull),
      .empty (wbEmpty),
      .head  (wbHead)
   );

   assign wbPop  = (state == WRB) && memReady;
   assign wbPush = we0 && (!wbFull || wbPop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         wbOverflow <= 1'b0;
      else if (we0 && wbFull && !wbPop) wbOverflow <= 1'b1;
   end

   // a read issued with a write must queue behind that write
   assign c0Req   = !wbEmpty || (re0 && !we0);
   assign c0Grant = wbEmpty ? RD0 : WRB;
   assign c1Req   = re1 | we1;

`ifdef ARB_ROUND_ROBIN_EN
   logic lastP1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         lastP1 <= 1'b1;
      else if (state == IDLE && (c0Req || c1Req))
         lastP1 <= (nextState == P1);
   end

   assign pick1 = c1Req && (!c0Req || !lastP1);
`else
   assign pick1 = c1Req && !c0Req;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      memRE     = 1'b0;
      memWE     = 1'b0;
      memAddr   = '0;
      memWrite  = '0;
      ready0    = !re0;
      rdata0    = '0;
      ready1    = 1'b0;
      rdata1    = '0;
      unique case (state)
         IDLE: begin
            if (pick1)      nextState = P1;
            else if (c0Req) nextState = c0Grant;
         end
         RD0: begin
            memRE   = 1'b1;
            memAddr = addr0;
            ready0  = memReady;
            rdata0  = memRead;
            if (memReady) nextState = IDLE;
         end
         WRB: begin
            memWE               = 1'b1;
            {memAddr, memWrite} = wbHead;
            if (memReady) nextState = IDLE;
         end
         P1: begin
            memRE    = re1;
            memWE    = we1;
            memAddr  = addr1;
            memWrite = wdata1;
            ready1   = memReady;
            rdata1   = memRead;
            if (memReady) nextState = IDLE;
         end
      endcase
   end

   assign owner = ownerOf(state);

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory port between the RCPU (port 0) and one secondary bus master such as DMA (port 1). Produces the RCPU's `memReady`, which stalls the RCPU on reads until data returns. Posts RCPU writes into a small write buffer, because the RCPU never stalls on writes. Sits between the RCPU and the memory/MMIO decoder.

## Interface
Parameters:
- `M`, 16, data width
- `N`, 32, address width
- `WB_DEPTH`, 2, write-buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock, rising edge. One clock; reset is asynchronous and active-low.
- `rst`  in  1  asynchronous active-low reset
- `addr0`  in  N  RCPU address
- `wdata0`  in  M  RCPU write data
- `re0`, `we0`  in  1  RCPU read / write strobes
- `ready0`  out  1  to RCPU `memReady`
- `rdata0`  out  M  to RCPU `memReadIn`
- `addr1`, `wdata1`, `re1`, `we1`  in  N/M/1/1  port-1 request, held until `ready1`
- `ready1`  out  1  port-1 transfer complete
- `rdata1`  out  M  port-1 read data
- `memAddr`, `memWrite`  out  N/M  memory address / write data
- `memRE`, `memWE`  out  1  memory strobes
- `memReady`  in  1  memory completes the current access this cycle
- `memRead`  in  M  memory read data
- `owner`  out  2  debug: 0 idle, 1 port0 read, 2 buffer write, 3 port1
- `wbOverflow`  out  1  sticky: an RCPU write was dropped

## Operation
- States: IDLE, RD0, WRB, P1.
- **Port-0 writes.** Each cycle with `we0=1` pushes {`addr0`,`wdata0`} into the FIFO, in any state.
  - Full FIFO with no pop in the same cycle: the write is dropped and `wbOverflow` is set until reset.
  - A pop and a push in the same cycle on a full FIFO is legal.
- **IDLE arbitration** (registered; the grant takes effect next cycle). Class 0 candidate, in order:
  - FIFO non-empty → WRB
  - else `re0` → RD0
  - Port-1 candidate: `re1|we1` → P1.
  - Both classes pending: resolved per Configuration.
- **RD0.** `memRE=1`, `memAddr=addr0`.
  - `ready0=memReady`, `rdata0=memRead` (combinational).
  - Return to IDLE when `memReady` is high.
- **WRB.** `memWE=1`, address and data from the FIFO head.
  - Pop and return to IDLE when `memReady` is high.
- **P1.** `memRE=re1`, `memWE=we1`, `memAddr=addr1`, `memWrite=wdata1`.
  - `ready1=memReady`, `rdata1=memRead`.
  - Return to IDLE when `memReady` is high.
- **Ordering.** A port-0 read never passes a buffered port-0 write.
  - While the FIFO is non-empty, `re0` waits with `ready0=0`.
- **`ready0` outside RD0.** `ready0=0` whenever `re0=1` outside RD0; `ready0=1` when `re0=0`.
- **`re0` and `we0` together.** The write is pushed; the read waits behind it.
- **Port-1 protocol.** `re1` and `we1` together is illegal; behaviour is undefined.
- **Reset.**
  - State goes to IDLE, FIFO empties, `wbOverflow=0`, `owner=0`.
  - All strobes, `ready1`, `rdata0`, `rdata1`, `memAddr` and `memWrite` are 0.
  - `ready0=1` when `re0=0`.
  - Reset mid-transfer deasserts the memory strobes immediately; the in-flight access is abandoned.

## Timing
- Port-0 read, zero-wait memory: `re0` at cycle t → RD0 at t+1 with `ready0=1` → IDLE at t+2. The RCPU sees 1 stall cycle.
- `memReady` low for k cycles extends RD0, WRB or P1 by k cycles.
- Every grant returns through IDLE: one bubble cycle between bus transfers.
- FIFO push is visible to arbitration the cycle after `we0`.
- Memory outputs are combinational from state plus the granted inputs; requesters hold their inputs stable while granted.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - 1-bit last-winner register; on contention in IDLE the class that did not win last time is granted.
  - The register updates on every grant and resets to "port 1 last".
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, class 0 always wins.
  - Port 1 can starve while RCPU traffic is continuous.

## Structure
- State encodings and `owner` codes go in the shared constants package, alongside the CPU's memory-source constants.
- Sub-module `write_buffer`:
  - synchronous FIFO of {N+M}-bit entries, depth `WB_DEPTH`;
  - push, pop, full, empty, head outputs;
  - asynchronous active-low reset.

## Test plan
- `re0`, `addr0`=0x0000_0010, memory returns 0xBEEF at zero wait → `ready0` high at t+1 with `rdata0`=0xBEEF; `memRE` low at t+2.
- `we0` at 0x20=0x1111 then `re0` at 0x20 the next cycle → memory sees WRB (write 0x1111) before RD0; `ready0` low until the read completes.
- Three back-to-back `we0` with `memReady` held low → first two buffered, third dropped, `wbOverflow`=1 until reset.
- `re0` and `re1` held continuously with zero-wait memory → with `ARB_ROUND_ROBIN_EN`, `owner` alternates 1,3,1,3; without it, `owner` stays 1 and `ready1` never asserts.
- P1 write with `memReady` low for 3 cycles, then reset asserted → `memWE`, `ready1` and `owner` go 0 immediately; after release, FIFO empty and state IDLE.
